// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the asynchronous FIFO pointer controllers.
//   SIDE_WR / SIDE_RD : values for the SIDE parameter of fifo_gray_ptr.
//   ptr_word_t        : wide container used by the width-generic Gray helper.
//   bin2gray(x)       : binary to reflected Gray code, (x >> 1) ^ x.
package fifo_pkg;

  localparam int SIDE_WR    = 0;
  localparam int SIDE_RD    = 1;
  localparam int PTR_WORD_W = 32;

  typedef logic [PTR_WORD_W-1:0] ptr_word_t;

  // Callers zero-extend into ptr_word_t and truncate the result back to their
  // pointer width; the low bits are unaffected by the extension.
  function automatic ptr_word_t bin2gray(input ptr_word_t x);
    return (x >> 1) ^ x;
  endfunction

endpackage

// File: rtl/fifo_gray_ptr_gray_to_bin.sv
// gray_to_bin: combinational Gray-to-binary converter (prefix XOR from the MSB).
// Parameters:
//   WIDTH : code width.
// Ports:
//   gray  : input Gray code.
//   bin   : binary equivalent; bin[WIDTH-1] = gray[WIDTH-1],
//           bin[i] = bin[i+1] ^ gray[i].
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    logic run;
    run = 1'b0;
    bin = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      run = run ^ gray[WIDTH-1-k];
      bin[WIDTH-1-k] = run;
    end
  end

endmodule

// File: rtl/fifo_gray_ptr.sv
// fifo_gray_ptr: pointer/flag controller for one side of an asynchronous FIFO.
// One instance lives in each clock domain. It owns the binary pointer, drives
// the RAM address, exports a registered Gray pointer for the other domain and
// produces full (write side) or empty (read side) from the synchronised
// opposite Gray pointer.
// Optional feature: define FIFO_PTR_LEVEL_EN to add the registered occupancy
// output `level` (and the Gray-to-binary converter it needs).
// Parameters:
//   ADDR_WIDTH : RAM address width (>= 2); pointers are ADDR_WIDTH+1 bits.
//   SIDE       : SIDE_WR (0) = write side, SIDE_RD (1) = read side.
// Ports:
//   CLK           : domain clock, rising edge.
//   RST           : asynchronous active-low reset.
//   inc           : write/read request this cycle.
//   sync_gray_ptr : opposite-side Gray pointer after the 2-FF synchroniser.
//   accept        : inc & ~flag, the operation happens this cycle.
//   addr          : RAM address (low bits of the binary pointer, pre-increment).
//   gray_ptr      : registered Gray pointer for the other domain.
//   flag          : registered full (write side) or empty (read side).
//   level         : registered occupancy 0..2^ADDR_WIDTH (FIFO_PTR_LEVEL_EN only).
module fifo_gray_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int SIDE       = SIDE_WR
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  inc,
  input  logic [ADDR_WIDTH:0]   sync_gray_ptr,
  output logic                  accept,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   gray_ptr,
  output logic                  flag
`ifdef FIFO_PTR_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level
`endif
);

  localparam int   PW       = ADDR_WIDTH + 1;
  localparam logic FLAG_RST = (SIDE == SIDE_RD);

  logic [ADDR_WIDTH:0] bin;
  logic [ADDR_WIDTH:0] bin_next;
  logic [ADDR_WIDTH:0] gray_next;
  logic                flag_next;

  assign accept    = inc & ~flag;
  assign addr      = bin[ADDR_WIDTH-1:0];
  assign bin_next  = bin + PW'(accept);
  assign gray_next = PW'(bin2gray(ptr_word_t'(bin_next)));

  // Full: the write pointer is exactly one lap ahead, which in Gray code means
  // the two MSBs are inverted and the rest match. Empty: pointers are equal.
  generate
    if (SIDE == SIDE_RD) begin : g_rd
      assign flag_next = (gray_next == sync_gray_ptr);
    end else begin : g_wr
      assign flag_next = (gray_next == {~sync_gray_ptr[ADDR_WIDTH:ADDR_WIDTH-1],
                                        sync_gray_ptr[ADDR_WIDTH-2:0]});
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bin      <= '0;
      gray_ptr <= '0;
      flag     <= FLAG_RST;
    end else begin
      bin      <= bin_next;
      gray_ptr <= gray_next;
      flag     <= flag_next;
    end
  end

`ifdef FIFO_PTR_LEVEL_EN
  logic [ADDR_WIDTH:0] sync_bin;

  gray_to_bin #(.WIDTH(PW)) u_sync_g2b (
    .gray (sync_gray_ptr),
    .bin  (sync_bin)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      level <= '0;
    end else if (SIDE == SIDE_RD) begin
      level <= sync_bin - bin_next;
    end else begin
      level <= bin_next - sync_bin;
    end
  end
`endif

endmodule

// File: doc/fifo_gray_ptr.md
# fifo_gray_ptr

Parametrised pointer/flag controller for one side of the asynchronous FIFO. It holds the binary pointer and drives the RAM address. It publishes a registered Gray-coded pointer for crossing into the other clock domain, and it generates the full flag (write side) or the empty flag (read side) from the already-synchronised opposite pointer. One instance runs in each clock domain. It replaces the fixed 4-bit binary-to-Gray lookup with width-generic conversion plus the pointer and flag sequencing.

## Interface
Parameters:
- ADDR_WIDTH, default 3: RAM address width; depth = 2^ADDR_WIDTH; legal range ≥ 2; pointers are ADDR_WIDTH+1 bits.
- SIDE, default 0: 0 = write side (flag means full); 1 = read side (flag means empty).

Ports:
- CLK, input, 1: domain clock; all state on rising edge.
- RST, input, 1: asynchronous, active-low reset.
- inc, input, 1: write or read request for this cycle.
- sync_gray_ptr, input, ADDR_WIDTH+1: opposite-side Gray pointer, already through the 2-FF synchroniser.
- accept, output, 1: combinational; inc & ~flag; the operation happens this cycle.
- addr, output, ADDR_WIDTH: RAM address; the low bits of the binary pointer.
- gray_ptr, output, ADDR_WIDTH+1: registered Gray pointer, exported to the other domain.
- flag, output, 1: registered full (SIDE=0) or empty (SIDE=1).
- level, output, ADDR_WIDTH+1: registered occupancy; present only with FIFO_PTR_LEVEL_EN.

## Operation
- Internal state: bin[ADDR_WIDTH:0], gray_ptr, flag, and level when enabled.
- bin_next = bin + accept, wrapping modulo 2^(ADDR_WIDTH+1).
- gray_next = (bin_next >> 1) ^ bin_next.
- Registers update every cycle: bin <= bin_next; gray_ptr <= gray_next.
- Write-side flag, every cycle: flag <= (gray_next == {~sync_gray_ptr[ADDR_WIDTH:ADDR_WIDTH-1], sync_gray_ptr[ADDR_WIDTH-2:0]}).
- Read-side flag, every cycle: flag <= (gray_next == sync_gray_ptr).
- The flag is re-evaluated even when inc = 0, so it clears when the opposite pointer advances.
- A request while flag = 1 is dropped: accept = 0 and the pointers hold. There is no error output.
- gray_ptr changes by exactly one bit per accepted operation, including the wrap from bin = 2^(ADDR_WIDTH+1)-1 to 0.
- Reset values: bin = 0, addr = 0, gray_ptr = 0, level = 0.
- flag reset value: 0 on the write side (not full); 1 on the read side (empty).
- Reset asserted mid-operation clears all state immediately and asynchronously. The other side must be reset in the same event; this block does not re-align with the other side by itself.

## Timing
- accept: zero latency from inc, gated by the current registered flag.
- addr: valid in the same cycle as accept, so the RAM write or read uses the pre-increment address.
- gray_ptr, flag, level: update at the rising edge that ends the accepted cycle (1-cycle latency).
- sync_gray_ptr is sampled every edge. A change is reflected in flag and level one edge later.
- Simultaneous inc and opposite-pointer advance while flag = 1: this cycle's request is rejected. The flag clears on the next edge, and the next request is accepted.

## Configuration
- Macro FIFO_PTR_LEVEL_EN.
- Defined: instantiate gray_to_bin on sync_gray_ptr. Register the occupancy as:
  - write side: level <= bin_next - sync_bin;
  - read side: level <= sync_bin - bin_next;
  - arithmetic modulo 2^(ADDR_WIDTH+1); range 0..2^ADDR_WIDTH.
- Undefined: the level port and the converter are absent; flag behaviour is identical.

## Structure
- Shared package fifo_pkg holds:
  - SIDE_WR = 0 and SIDE_RD = 1;
  - function bin2gray(x) = (x >> 1) ^ x.
- Sub-module gray_to_bin (parameter WIDTH): combinational prefix-XOR, with b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] ^ g[i].

## Test plan
All scenarios use ADDR_WIDTH = 3, so the pointers are 4 bits wide.
- Reset: drive RST low for 2 cycles. Expect gray_ptr = 0, addr = 0, level = 0, write flag = 0, read flag = 1.
- Write fill: SIDE=0, sync_gray_ptr = 0, inc held for 8 cycles.
  - gray_ptr goes 1, 3, 2, 6, 7, 5, 4, 4'b1100.
  - flag = 1 after the 8th edge; level = 8.
  - A 9th inc gives accept = 0; addr holds at 0.
- Read drain: SIDE=1, sync_gray_ptr = 4'b0110 (binary 4).
  - flag goes 1 → 0 one edge after the sync input is applied; level = 4.
  - 4 reads: addr goes 0..3, level counts down 3, 2, 1, 0, and flag = 1 after the 4th read.
- Wrap: 16 accepted writes, with sync kept 4 behind.
  - bin goes 15 → 0, gray_ptr goes 4'b1000 → 4'b0000.
  - Exactly one gray_ptr bit changes per step throughout.
- Simultaneous: write side full, then sync_gray_ptr advances by one in the same cycle as inc.
  - That cycle gives accept = 0.
  - The next edge gives flag = 0; the next inc is accepted and flag = 1 again.
- Mid-run reset: pulse RST low asynchronously between edges after 5 writes.
  - All outputs return to their reset values immediately.
  - The first write afterwards uses addr = 0.
